// File: rtl/frame_stream_writer.sv
/******************************************************************************
 * Module   : frame_stream_writer
 * Purpose  : Writes one geometry-checked raster frame from a valid/ready stream
 *            into the windowed pixel FIFO, then hands off to the window reader.
 * Options  : FRAME_WRITER_LINE_CHECK_EN - enforce s_eol on the last column only
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module frame_stream_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 33,
  parameter int ROWS       = 33,
  parameter int DEPTH      = 4096,
  localparam int COLBITS   = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int ROWBITS   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic                  s_ready,
  input  logic                  fifo_full,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  load_addr,
  input  logic                  window_done,
  output logic                  frame_done,
  output logic                  err,
  output logic [ROWBITS-1:0]    row_idx
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_SOF  = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] LOAD      = 3'd3;
  localparam logic [2:0] READ_WAIT = 3'd4;
  localparam logic [2:0] ERR       = 3'd5;

  localparam logic [COLBITS-1:0] c_LAST_COL = COLBITS'(COLS - 1);
  localparam logic [ROWBITS-1:0] c_LAST_ROW = ROWBITS'(ROWS - 1);

  generate
    if (COLS * ROWS > DEPTH - 1) begin : g_depth_check
      $error("frame_stream_writer: COLS*ROWS must not exceed DEPTH-1");
    end
  endgenerate

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [COLBITS-1:0] r_col;
  logic               w_xfer;
  logic               w_in_frame;
  logic               w_sof_err;
  logic               w_eol_err;
  logic               w_bad;
  logic               w_wr;
  logic               w_last;
  logic               w_arm_ok;

  assign s_ready    = ((r_state == WAIT_SOF) || (r_state == WRITE)) && !fifo_full;
  assign w_xfer     = s_valid && s_ready;
  // In WAIT_SOF only the SOF beat belongs to the frame; everything else is dropped.
  assign w_in_frame = (r_state == WRITE) || ((r_state == WAIT_SOF) && s_sof);
  assign w_sof_err  = (r_state == WRITE) && s_sof;

`ifdef FRAME_WRITER_LINE_CHECK_EN
  assign w_eol_err  = (r_col == c_LAST_COL) != s_eol;
`else
  logic w_eol_unused;
  assign w_eol_unused = s_eol;
  assign w_eol_err    = 1'b0;
`endif

  assign w_bad    = w_in_frame && (w_sof_err || w_eol_err);
  assign w_wr     = w_xfer && w_in_frame && !w_bad;
  assign w_last   = (r_col == c_LAST_COL) && (row_idx == c_LAST_ROW);
  assign w_arm_ok = arm && ((r_state == IDLE) || (r_state == ERR));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (arm) w_next = WAIT_SOF;
      WAIT_SOF,
      WRITE: begin
        if (w_xfer && w_in_frame) begin
          if (w_bad)       w_next = ERR;
          else if (w_last) w_next = LOAD;
          else             w_next = WRITE;
        end
      end
      LOAD:      w_next = READ_WAIT;
      READ_WAIT: if (window_done) w_next = IDLE;
      ERR:       if (arm) w_next = WAIT_SOF;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_col      <= '0;
      row_idx    <= '0;
      w_en       <= 1'b0;
      data_in    <= '0;
      load_addr  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state   <= w_next;
      w_en      <= w_wr;
      load_addr <= (r_state == LOAD);

      if (w_wr) begin
        data_in <= s_data;
        if (r_col == c_LAST_COL) begin
          r_col   <= '0;
          row_idx <= w_last ? '0 : row_idx + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_arm_ok) begin
        r_col      <= '0;
        row_idx    <= '0;
        frame_done <= 1'b0;
        err        <= 1'b0;
      end

      if (r_state == LOAD)
        frame_done <= 1'b1;
      if ((w_next == ERR) && (r_state != ERR))
        err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_frame_stream_writer.sv
/******************************************************************************
 * Module   : tb_frame_stream_writer
 * Purpose  : Directed self-checking bench for frame_stream_writer (33x33 frames).
 * Revision : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module tb_frame_stream_writer;

  localparam int NPIX = 33 * 33;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_sof = 1'b0;
  logic       s_eol = 1'b0;
  logic       s_ready;
  logic       fifo_full = 1'b0;
  logic       w_en;
  logic [7:0] data_in;
  logic       load_addr;
  logic       window_done = 1'b0;
  logic       frame_done;
  logic       err;
  logic [5:0] row_idx;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cnt_load = 0;
  logic [7:0] wq[$];
  logic [7:0] exp_q[$];

  frame_stream_writer #(
    .DATA_WIDTH(8), .COLS(33), .ROWS(33), .DEPTH(4096)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .s_valid(s_valid), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol), .s_ready(s_ready), .fifo_full(fifo_full),
    .w_en(w_en), .data_in(data_in), .load_addr(load_addr),
    .window_done(window_done), .frame_done(frame_done), .err(err),
    .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_en) wq.push_back(data_in);
    if (load_addr) cnt_load++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input bit do_arm, input bit do_done);
    arm = do_arm;
    window_done = do_done;
    @(negedge clk);
    arm = 1'b0;
    window_done = 1'b0;
  endtask

  // Holds a beat until accepted; returns on the negedge after the transfer edge.
  task automatic send_beat(input logic [7:0] d, input logic sof, input logic eol);
    int  n = 0;
    logic rdy;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    do begin
      #1 rdy = s_ready;
      @(negedge clk);
      n++;
    end while (!rdy && n < 50);
    if (!rdy) check("beat_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input int junk, input int bp_at, input int bad_eol_at,
                           input int rst_at, input logic [7:0] first_pix);
    int base_load = cnt_load;
    int mism = 0;
    wq.delete();
    exp_q.delete();
    for (int j = 0; j < junk; j++) send_beat(8'hAA, 1'b0, 1'b0);
    for (int i = 0; i < NPIX; i++) begin
      int r = i / 33;
      int c = i % 33;
      logic [7:0] d = (i == 0) ? first_pix : 8'((r * 33 + c) & 255);
      if (i == rst_at) begin
        rst = 1'b0; s_valid = 1'b0;
        #1;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_w_en", {31'd0, w_en}, 32'd0);
        check("rst_row_idx", {26'd0, row_idx}, 32'd0);
        check("rst_err_fd_ld", {29'd0, err, frame_done, load_addr}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_no_load", cnt_load, base_load);
        check("rst_idle_ready", {31'd0, s_ready}, 32'd0);
        return;
      end
      if (i == bp_at) begin
        check("bp_row", {26'd0, row_idx}, r);
        fifo_full = 1'b1;
        s_valid = 1'b1; s_data = d; s_sof = 1'b0; s_eol = (c == 32);
        for (int k = 0; k < 4; k++) begin
          #1 check("bp_s_ready", {31'd0, s_ready}, 32'd0);
          @(negedge clk);
          check("bp_w_en", {31'd0, w_en}, 32'd0);
        end
        fifo_full = 1'b0;
      end
      send_beat(d, i == 0, (c == 32) || (i == bad_eol_at));
`ifdef FRAME_WRITER_LINE_CHECK_EN
      if (i == bad_eol_at) begin
        check("eol_err", {31'd0, err}, 32'd1);
        check("eol_s_ready", {31'd0, s_ready}, 32'd0);
        check("eol_w_en", {31'd0, w_en}, 32'd0);
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("eol_wr_count", wq.size(), i);
        check("eol_no_load", cnt_load, base_load);
        return;
      end
`endif
      exp_q.push_back(d);
    end
    s_valid = 1'b0;
    check("last_w_en", {31'd0, w_en}, 32'd1);
    check("last_s_ready", {31'd0, s_ready}, 32'd0);
    check("last_load_early", {31'd0, load_addr}, 32'd0);
    @(negedge clk);
    check("load_pulse", {31'd0, load_addr}, 32'd1);
    check("frame_done", {31'd0, frame_done}, 32'd1);
    check("post_w_en", {31'd0, w_en}, 32'd0);
    @(negedge clk);
    check("load_width", {31'd0, load_addr}, 32'd0);
    repeat (3) @(negedge clk);
    check("load_count", cnt_load - base_load, 32'd1);
    check("wr_count", wq.size(), NPIX);
    for (int i = 0; i < NPIX && i < wq.size(); i++)
      if (wq[i] !== exp_q[i]) mism++;
    check("wr_data", mism, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    s_valid = 1'b1; s_sof = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {26'd0, s_ready, w_en, load_addr, frame_done, err, |row_idx}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_s_ready", {31'd0, s_ready}, 32'd0);
    check("idle_no_write", wq.size(), 32'd0);
    s_valid = 1'b0; s_sof = 1'b0;

    // Nominal ramp frame
    pulse(1'b1, 1'b0);
    run_frame(0, -1, -1, -1, 8'h00);

    // arm is ignored while waiting on the reader, and dropped with window_done
    pulse(1'b1, 1'b0);
    check("rw_arm_ignored", {31'd0, frame_done}, 32'd1);
    check("rw_s_ready", {31'd0, s_ready}, 32'd0);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    check("rw_arm_dropped", {31'd0, frame_done}, 32'd1);
    pulse(1'b1, 1'b0);
    check("arm_clears_done", {31'd0, frame_done}, 32'd0);
    check("arm_s_ready", {31'd0, s_ready}, 32'd1);

    // Pre-SOF junk plus backpressure at row 7 col 20
    run_frame(5, 7 * 33 + 20, -1, -1, 8'h11);
    pulse(1'b0, 1'b1);

    // Stray s_eol at row 3 col 10
    pulse(1'b1, 1'b0);
    run_frame(0, -1, 3 * 33 + 10, -1, 8'h00);
    pulse(1'b0, 1'b1);

    // Reset mid-frame at row 12, then two clean frames
    pulse(1'b1, 1'b0);
    run_frame(0, -1, -1, 12 * 33, 8'h00);
    pulse(1'b1, 1'b0);
    run_frame(0, -1, -1, -1, 8'h00);
    pulse(1'b0, 1'b1);
    @(negedge clk);
    check("done_idle_ready", {31'd0, s_ready}, 32'd0);
    pulse(1'b1, 1'b0);
    run_frame(0, -1, -1, -1, 8'h00);
    pulse(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
